// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel-rate divider, h/v position, registered syncs and draw window.
// Optional VGA_PREFETCH_EN adds fetch outputs that lead the draw outputs by one pixel.
module vga_timing #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int HSYNC_POL   = 0,
  parameter int VSYNC_POL   = 0,
  parameter int CLK_DIV     = 4,
  parameter int FRAME_CNT_W = 8,
  parameter int X_W         = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  parameter int Y_W         = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   o_pix_tick,
  output logic                   o_draw_active,
  output logic [X_W-1:0]         o_active_x,
  output logic [Y_W-1:0]         o_active_y,
  output logic                   o_h_sync,
  output logic                   o_v_sync,
  output logic                   o_line_start,
  output logic                   o_frame_start,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt
`ifdef VGA_PREFETCH_EN
  ,
  output logic                   o_fetch_active,
  output logic [X_W-1:0]         o_fetch_x,
  output logic [Y_W-1:0]         o_fetch_y
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [H_W-1:0]   H_LAST    = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   H_ONE     = H_W'(1);
  localparam logic [H_W-1:0]   H_VIS_END = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]   HS_BEG    = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   HS_END    = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0]   V_LAST    = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   V_ONE     = V_W'(1);
  localparam logic [V_W-1:0]   V_VIS_END = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]   VS_BEG    = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   VS_END    = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic             HS_ON     = (HSYNC_POL != 0);
  localparam logic             VS_ON     = (VSYNC_POL != 0);

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        CLK_DIV < 1 || FRAME_CNT_W < 1) begin : g_param_err
      $error("vga_timing: every timing parameter and CLK_DIV must be at least 1");
    end
  endgenerate

  function automatic logic [H_W-1:0] f_h_step(input logic [H_W-1:0] h);
    return (h == H_LAST) ? '0 : h + H_ONE;
  endfunction

  function automatic logic [V_W-1:0] f_v_step(input logic [V_W-1:0] v, input logic [H_W-1:0] h);
    if (h != H_LAST) return v;
    return (v == V_LAST) ? '0 : v + V_ONE;
  endfunction

  function automatic logic f_active(input logic [H_W-1:0] h, input logic [V_W-1:0] v);
    return (h < H_VIS_END) && (v < V_VIS_END);
  endfunction

  function automatic logic [X_W-1:0] f_x(input logic [H_W-1:0] h, input logic [V_W-1:0] v);
    return f_active(h, v) ? h[X_W-1:0] : '0;
  endfunction

  function automatic logic [Y_W-1:0] f_y(input logic [H_W-1:0] h, input logic [V_W-1:0] v);
    return f_active(h, v) ? v[Y_W-1:0] : '0;
  endfunction

  logic [DIV_W-1:0]       r_div;
  logic [H_W-1:0]         r_h;
  logic [V_W-1:0]         r_v;
  logic                   r_pix_tick;
  logic                   r_draw_active;
  logic [X_W-1:0]         r_active_x;
  logic [Y_W-1:0]         r_active_y;
  logic                   r_h_sync;
  logic                   r_v_sync;
  logic                   r_line_start;
  logic                   r_frame_start;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  logic                   w_tick;
  logic [H_W-1:0]         w_h_nx;
  logic [V_W-1:0]         w_v_nx;
  logic                   w_enter_line;
  logic                   w_enter_frame;

  // Outputs are registered from the position being entered, so they change on the tick edge itself.
  assign w_tick        = (r_div == DIV_LAST);
  assign w_h_nx        = f_h_step(r_h);
  assign w_v_nx        = f_v_step(r_v, r_h);
  assign w_enter_line  = (w_h_nx == '0);
  assign w_enter_frame = w_enter_line && (w_v_nx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_h   <= H_LAST;
      r_v   <= V_LAST;
    end else begin
      r_div <= w_tick ? '0 : r_div + DIV_ONE;
      if (w_tick) begin
        r_h <= w_h_nx;
        r_v <= w_v_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_tick    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '1;
    end else begin
      r_pix_tick    <= w_tick;
      r_line_start  <= w_tick && w_enter_line;
      r_frame_start <= w_tick && w_enter_frame;
      if (w_tick && w_enter_frame) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_draw_active <= 1'b0;
      r_active_x    <= '0;
      r_active_y    <= '0;
      r_h_sync      <= ~HS_ON;
      r_v_sync      <= ~VS_ON;
    end else if (w_tick) begin
      r_draw_active <= f_active(w_h_nx, w_v_nx);
      r_active_x    <= f_x(w_h_nx, w_v_nx);
      r_active_y    <= f_y(w_h_nx, w_v_nx);
      r_h_sync      <= ((w_h_nx >= HS_BEG) && (w_h_nx < HS_END)) ? HS_ON : ~HS_ON;
      r_v_sync      <= ((w_v_nx >= VS_BEG) && (w_v_nx < VS_END)) ? VS_ON : ~VS_ON;
    end
  end

  assign o_pix_tick    = r_pix_tick;
  assign o_draw_active = r_draw_active;
  assign o_active_x    = r_active_x;
  assign o_active_y    = r_active_y;
  assign o_h_sync      = r_h_sync;
  assign o_v_sync      = r_v_sync;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;
  assign o_frame_cnt   = r_frame_cnt;

`ifdef VGA_PREFETCH_EN
  logic           r_fetch_active;
  logic [X_W-1:0] r_fetch_x;
  logic [Y_W-1:0] r_fetch_y;
  logic [H_W-1:0] w_h_nx2;
  logic [V_W-1:0] w_v_nx2;

  // Fetch looks one pixel past the position being entered; the reset position's successor is (0,0).
  assign w_h_nx2 = f_h_step(w_h_nx);
  assign w_v_nx2 = f_v_step(w_v_nx, w_h_nx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_active <= 1'b1;
      r_fetch_x      <= '0;
      r_fetch_y      <= '0;
    end else if (w_tick) begin
      r_fetch_active <= f_active(w_h_nx2, w_v_nx2);
      r_fetch_x      <= f_x(w_h_nx2, w_v_nx2);
      r_fetch_y      <= f_y(w_h_nx2, w_v_nx2);
    end
  end

  assign o_fetch_active = r_fetch_active;
  assign o_fetch_x      = r_fetch_x;
  assign o_fetch_y      = r_fetch_y;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Randomized-segment bench for vga_timing: expected outputs come from a raster-index model
// (tick count -> linear pixel index -> h,v), with random asynchronous reset pulses between segments.
module tb_vga_timing;
  localparam int HA = 5, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 2;
  localparam int HPOL = 1, VPOL = 0;
  localparam int DIV = 3;
  localparam int FCW = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int F  = HT * VT;
  localparam int XW = $clog2(HA);
  localparam int YW = $clog2(VA);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           o_pix_tick, o_draw_active, o_h_sync, o_v_sync, o_line_start, o_frame_start;
  logic [XW-1:0]  o_active_x;
  logic [YW-1:0]  o_active_y;
  logic [FCW-1:0] o_frame_cnt;
`ifdef VGA_PREFETCH_EN
  logic           o_fetch_active;
  logic [XW-1:0]  o_fetch_x;
  logic [YW-1:0]  o_fetch_y;
`endif

  int checks = 0;
  int errors = 0;
  int e = 0;

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .CLK_DIV(DIV), .FRAME_CNT_W(FCW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .o_pix_tick(o_pix_tick), .o_draw_active(o_draw_active),
    .o_active_x(o_active_x), .o_active_y(o_active_y),
    .o_h_sync(o_h_sync), .o_v_sync(o_v_sync),
    .o_line_start(o_line_start), .o_frame_start(o_frame_start),
    .o_frame_cnt(o_frame_cnt)
`ifdef VGA_PREFETCH_EN
    , .o_fetch_active(o_fetch_active), .o_fetch_x(o_fetch_x), .o_fetch_y(o_fetch_y)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d edge=%0d", tag, obs, exp, e);
    end
  endtask

  // ee = rising edges since reset release (0 = held in or just out of reset)
  task automatic check_all(input int ee);
    int k, p, h, v, fh, fv, starts;
    bit tk, act, fact;
    k  = ee / DIV;
    tk = (ee > 0) && (ee % DIV == 0);
    if (k == 0) begin
      h = HT - 1;
      v = VT - 1;
    end else begin
      p = (k - 1) % F;
      h = p % HT;
      v = p / HT;
    end
    act    = (h < HA) && (v < VA);
    starts = (k + F - 1) / F;
    check("pix_tick",    32'(o_pix_tick),    32'(tk));
    check("draw_active", 32'(o_draw_active), 32'(act));
    check("active_x",    32'(o_active_x),    act ? h : 0);
    check("active_y",    32'(o_active_y),    act ? v : 0);
    check("h_sync",      32'(o_h_sync),      (h >= HA + HFP && h < HA + HFP + HS) ? HPOL : 1 - HPOL);
    check("v_sync",      32'(o_v_sync),      (v >= VA + VFP && v < VA + VFP + VS) ? VPOL : 1 - VPOL);
    check("line_start",  32'(o_line_start),  32'(tk && h == 0));
    check("frame_start", 32'(o_frame_start), 32'(tk && h == 0 && v == 0));
    check("frame_cnt",   32'(o_frame_cnt),   (starts + (1 << FCW) - 1) % (1 << FCW));
    p    = k % F;
    fh   = p % HT;
    fv   = p / HT;
    fact = (fh < HA) && (fv < VA);
`ifdef VGA_PREFETCH_EN
    check("fetch_active", 32'(o_fetch_active), 32'(fact));
    check("fetch_x",      32'(o_fetch_x),      fact ? fh : 0);
    check("fetch_y",      32'(o_fetch_y),      fact ? fv : 0);
`else
    if (fact && fh >= HA) check("fetch_model", 32'(fh), 32'(0));
`endif
  endtask

  initial begin
    int n, d;
    #12;
    check_all(0);
    $display("reset hold: reset values checked at t=%0t", $time);
    rst_n = 1'b1;
    e = 0;
    for (int seg = 0; seg < 8; seg++) begin
      n = (seg == 0) ? 1400 + int'($urandom_range(0, 200)) : int'($urandom_range(30, 600));
      repeat (n) begin
        @(posedge clk);
        e++;
        #1;
        check_all(e);
      end
      $display("segment %0d: %0d clks checked, frame_cnt=%0d", seg, n, o_frame_cnt);
      d = int'($urandom_range(1, 3));
      #(d);
      rst_n = 1'b0;
      #1;
      e = 0;
      check_all(0);
      #2;
      rst_n = 1'b1;
      $display("mid-line reset pulse %0d: 3 ns low, reset values checked", seg);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
